// File: rtl/shunt_fringe_if.sv
// shunt_fringe_if
// Signal-exchange hub for one fringe node. A small database of entries, each
// tagged PUT source, GET destination or unused. A put on a source forwards its
// word into the linked destination and marks it fresh; a get on a fresh
// destination returns the word once. Also holds the node identity registers
// programmed by the link anchor at start-up.

module shunt_fringe_if #(
    parameter int N_SIGNALS = 16,
    parameter int DATA_W    = 64,
    localparam int IW       = (N_SIGNALS > 1) ? $clog2(N_SIGNALS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,

    input  logic                 i_cfg_we,
    input  logic [IW-1:0]        i_cfg_idx,
    input  logic [1:0]           i_cfg_type,
    input  logic [IW-1:0]        i_cfg_peer,

    input  logic                 i_put,
    input  logic [IW-1:0]        i_put_idx,
    input  logic [DATA_W-1:0]    i_put_data,

    input  logic                 i_get,
    input  logic [IW-1:0]        i_get_idx,

    input  logic                 i_iam_we,
    input  logic [31:0]          i_iam,
    input  logic                 i_status_we,
    input  logic [1:0]           i_status,
    input  logic                 i_simid_we,
    input  logic [31:0]          i_simid,

    output logic                 o_put_success,
    output logic                 o_get_success,
    output logic [DATA_W-1:0]    o_get_data,
    output logic [N_SIGNALS-1:0] o_valid_get,
    output logic [N_SIGNALS-1:0] o_fresh,
    output logic [31:0]          o_iam,
    output logic [1:0]           o_status,
    output logic [31:0]          o_simid
);

    // Entry type encoding. The reserved code is stored as written but never
    // matches PUT or GET, so it behaves exactly like NONE.
    localparam logic [1:0] TYPE_NONE = 2'd0;
    localparam logic [1:0] TYPE_PUT  = 2'd1;
    localparam logic [1:0] TYPE_GET  = 2'd2;

    logic [1:0]           ent_type  [N_SIGNALS];
    logic [IW-1:0]        ent_peer  [N_SIGNALS];
    logic [DATA_W-1:0]    ent_data  [N_SIGNALS];
    logic [N_SIGNALS-1:0] ent_fresh;

    logic                 cfg_ok;
    logic [1:0]           put_src_type;
    logic [IW-1:0]        put_dst_idx;
    logic [1:0]           put_dst_type;
    logic                 put_ok;
    logic [1:0]           get_type;
    logic                 get_fresh;
    logic [DATA_W-1:0]    get_word;
    logic                 get_ok;

    // Indices beyond N_SIGNALS can only occur when N_SIGNALS is not a power
    // of two; such accesses must fail rather than alias onto real entries.
    function automatic logic in_range(input logic [IW-1:0] idx);
        return ({{(32-IW){1'b0}}, idx} < 32'(N_SIGNALS));
    endfunction

    // Decode put/get/config legality from the pre-edge descriptors only.
    always_comb begin
        put_src_type = TYPE_NONE;
        put_dst_idx  = '0;
        put_dst_type = TYPE_NONE;
        get_type     = TYPE_NONE;
        get_fresh    = 1'b0;
        get_word     = '0;

        cfg_ok = i_cfg_we && in_range(i_cfg_idx);

        if (in_range(i_put_idx)) begin
            put_src_type = ent_type[i_put_idx];
            put_dst_idx  = ent_peer[i_put_idx];
        end
        if (in_range(put_dst_idx)) begin
            put_dst_type = ent_type[put_dst_idx];
        end
        put_ok = i_put && (put_src_type == TYPE_PUT) && (put_dst_type == TYPE_GET);

        if (in_range(i_get_idx)) begin
            get_type  = ent_type[i_get_idx];
            get_fresh = ent_fresh[i_get_idx];
            get_word  = ent_data[i_get_idx];
        end
        get_ok = i_get && (get_type == TYPE_GET) && get_fresh;
    end

    // Database update. Order inside the loop sets priority on the same entry:
    // config, then get-clear, then put-set, so a same-cycle put leaves the
    // destination fresh after a get has consumed the old value.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            for (int i = 0; i < N_SIGNALS; i++) begin
                ent_type[i]  <= TYPE_NONE;
                ent_peer[i]  <= '0;
                ent_data[i]  <= '0;
                ent_fresh[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_SIGNALS; i++) begin
                if (cfg_ok && (i_cfg_idx == IW'(i))) begin
                    ent_type[i] <= i_cfg_type;
                    ent_peer[i] <= i_cfg_peer;
                    if (i_cfg_type != TYPE_GET) begin
                        ent_fresh[i] <= 1'b0;
                    end
                end
                if (get_ok && (i_get_idx == IW'(i))) begin
                    ent_fresh[i] <= 1'b0;
                end
                if (put_ok && (put_dst_idx == IW'(i))) begin
                    ent_data[i]  <= i_put_data;
                    ent_fresh[i] <= 1'b1;
                end
            end
        end
    end

    // Registered put/get results; get data holds until the next successful get.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_put_success <= 1'b0;
            o_get_success <= 1'b0;
            o_get_data    <= '0;
        end else begin
            o_put_success <= put_ok;
            o_get_success <= get_ok;
            if (get_ok) begin
                o_get_data <= get_word;
            end
        end
    end

    // Node identity registers, each with its own write enable.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_iam    <= '0;
            o_status <= 2'd0;
            o_simid  <= '0;
        end else begin
            if (i_iam_we) begin
                o_iam <= i_iam;
            end
            if (i_status_we) begin
                o_status <= i_status;
            end
            if (i_simid_we) begin
                o_simid <= i_simid;
            end
        end
    end

    // Per-entry GET tag view of the registered descriptors.
    always_comb begin
        o_valid_get = '0;
        for (int i = 0; i < N_SIGNALS; i++) begin
            o_valid_get[i] = (ent_type[i] == TYPE_GET);
        end
    end

    assign o_fresh = ent_fresh;

endmodule

// File: tb/tb_shunt_fringe_if.sv
// Bench for shunt_fringe_if: a directed vector table, identity and
// reset-in-flight sequences, then randomized traffic against a reference
// model of the exchange rules.

module tb_shunt_fringe_if;

    localparam int N  = 16;
    localparam int DW = 64;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [1:0]    cfg_type;
    logic [IW-1:0] cfg_peer;
    logic          put;
    logic [IW-1:0] put_idx;
    logic [DW-1:0] put_data;
    logic          get;
    logic [IW-1:0] get_idx;
    logic          iam_we;
    logic [31:0]   iam;
    logic          status_we;
    logic [1:0]    status;
    logic          simid_we;
    logic [31:0]   simid;

    logic          put_success;
    logic          get_success;
    logic [DW-1:0] get_data;
    logic [N-1:0]  valid_get;
    logic [N-1:0]  fresh;
    logic [31:0]   iam_q;
    logic [1:0]    status_q;
    logic [31:0]   simid_q;

    shunt_fringe_if #(.N_SIGNALS(N), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_type(cfg_type), .i_cfg_peer(cfg_peer),
        .i_put(put), .i_put_idx(put_idx), .i_put_data(put_data),
        .i_get(get), .i_get_idx(get_idx),
        .i_iam_we(iam_we), .i_iam(iam),
        .i_status_we(status_we), .i_status(status),
        .i_simid_we(simid_we), .i_simid(simid),
        .o_put_success(put_success), .o_get_success(get_success), .o_get_data(get_data),
        .o_valid_get(valid_get), .o_fresh(fresh),
        .o_iam(iam_q), .o_status(status_q), .o_simid(simid_q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a signal database as described by the exchange rules.
    typedef enum int {K_NONE, K_PUT, K_GET} kind_t;
    kind_t         m_kind  [N];
    int            m_peer  [N];
    logic [DW-1:0] m_data  [N];
    bit            m_fresh [N];
    bit            e_put, e_get;
    logic [DW-1:0] e_gdata;
    logic [31:0]   e_iam, e_simid;
    logic [1:0]    e_status;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic kind_t to_kind(input logic [1:0] t);
        if (t == 2'd1) return K_PUT;
        if (t == 2'd2) return K_GET;
        return K_NONE;
    endfunction

    function automatic logic [N-1:0] m_fresh_vec();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_fresh[i];
        return v;
    endfunction

    function automatic logic [N-1:0] m_get_vec();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = (m_kind[i] == K_GET);
        return v;
    endfunction

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_edge();
        bit pok, gok;
        int src, dst, gi;
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                m_kind[i] = K_NONE; m_peer[i] = 0; m_data[i] = '0; m_fresh[i] = 0;
            end
            e_put = 0; e_get = 0; e_gdata = '0;
            e_iam = '0; e_status = '0; e_simid = '0;
            return;
        end
        src = int'(put_idx);
        dst = m_peer[src];
        gi  = int'(get_idx);
        pok = put && m_kind[src] == K_PUT && m_kind[dst] == K_GET;
        gok = get && m_kind[gi] == K_GET && m_fresh[gi];
        e_put = pok;
        e_get = gok;
        if (gok) e_gdata = m_data[gi];
        if (cfg_we) begin
            m_kind[cfg_idx] = to_kind(cfg_type);
            m_peer[cfg_idx] = int'(cfg_peer);
            if (m_kind[cfg_idx] != K_GET) m_fresh[cfg_idx] = 0;
        end
        if (gok) m_fresh[gi] = 0;
        if (pok) begin
            m_data[dst]  = put_data;
            m_fresh[dst] = 1;
        end
        if (iam_we)    e_iam    = iam;
        if (status_we) e_status = status;
        if (simid_we)  e_simid  = simid;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("put_success", put_success, e_put);
        chk("get_success", get_success, e_get);
        chk("get_data",    get_data,    e_gdata);
        chk("fresh",       fresh,       m_fresh_vec());
        chk("valid_get",   valid_get,   m_get_vec());
        chk("iam",         iam_q,       e_iam);
        chk("status",      status_q,    e_status);
        chk("simid",       simid_q,     e_simid);
    endtask

    task automatic idle_in();
        cfg_we = 0; cfg_idx = '0; cfg_type = '0; cfg_peer = '0;
        put = 0; put_idx = '0; put_data = '0;
        get = 0; get_idx = '0;
        iam_we = 0; iam = '0; status_we = 0; status = '0; simid_we = 0; simid = '0;
    endtask

    typedef struct {
        logic          cw;
        logic [IW-1:0] ci;
        logic [1:0]    ct;
        logic [IW-1:0] cp;
        logic          p;
        logic [IW-1:0] pi;
        logic [DW-1:0] pd;
        logic          g;
        logic [IW-1:0] gi;
        logic          ep;
        logic          eg;
        logic [DW-1:0] ed;
        logic [N-1:0]  ef;
        logic [N-1:0]  ev;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    initial begin
        // cw ci ct cp | p pi pd | g gi | ep eg ed ef ev
        tbl[0]  = '{0, 0, 0, 0,  0, 0, 0,      1, 0,  0, 0, 0,      16'h0000, 16'h0000};
        tbl[1]  = '{1, 1, 1, 2,  0, 0, 0,      0, 0,  0, 0, 0,      16'h0000, 16'h0000};
        tbl[2]  = '{1, 2, 2, 0,  0, 0, 0,      0, 0,  0, 0, 0,      16'h0000, 16'h0004};
        tbl[3]  = '{0, 0, 0, 0,  1, 1, 64'h1,  0, 0,  1, 0, 0,      16'h0004, 16'h0004};
        tbl[4]  = '{0, 0, 0, 0,  0, 0, 0,      1, 2,  0, 1, 64'h1,  16'h0000, 16'h0004};
        tbl[5]  = '{0, 0, 0, 0,  0, 0, 0,      1, 2,  0, 0, 64'h1,  16'h0000, 16'h0004};
        tbl[6]  = '{0, 0, 0, 0,  1, 1, 64'hA,  0, 0,  1, 0, 64'h1,  16'h0004, 16'h0004};
        tbl[7]  = '{0, 0, 0, 0,  1, 1, 64'hB,  0, 0,  1, 0, 64'h1,  16'h0004, 16'h0004};
        tbl[8]  = '{0, 0, 0, 0,  0, 0, 0,      1, 2,  0, 1, 64'hB,  16'h0000, 16'h0004};
        tbl[9]  = '{0, 0, 0, 0,  0, 0, 0,      1, 2,  0, 0, 64'hB,  16'h0000, 16'h0004};
        tbl[10] = '{0, 0, 0, 0,  1, 3, 64'h7,  0, 0,  0, 0, 64'hB,  16'h0000, 16'h0004};
        tbl[11] = '{1, 4, 1, 5,  0, 0, 0,      0, 0,  0, 0, 64'hB,  16'h0000, 16'h0004};
        tbl[12] = '{0, 0, 0, 0,  1, 4, 64'h9,  0, 0,  0, 0, 64'hB,  16'h0000, 16'h0004};
        tbl[13] = '{0, 0, 0, 0,  1, 1, 64'h5,  0, 0,  1, 0, 64'hB,  16'h0004, 16'h0004};
        tbl[14] = '{0, 0, 0, 0,  1, 4, 64'h9,  0, 0,  0, 0, 64'hB,  16'h0004, 16'h0004};
        tbl[15] = '{0, 0, 0, 0,  1, 1, 64'h6,  1, 2,  1, 1, 64'h5,  16'h0004, 16'h0004};
        tbl[16] = '{0, 0, 0, 0,  0, 0, 0,      1, 2,  0, 1, 64'h6,  16'h0000, 16'h0004};
        tbl[17] = '{1, 5, 2, 0,  1, 4, 64'h9,  0, 0,  0, 0, 64'h6,  16'h0000, 16'h0024};
        tbl[18] = '{0, 0, 0, 0,  1, 4, 64'h9,  0, 0,  1, 0, 64'h6,  16'h0020, 16'h0024};
        tbl[19] = '{0, 0, 0, 0,  0, 0, 0,      1, 5,  0, 1, 64'h9,  16'h0000, 16'h0024};
        tbl[20] = '{0, 0, 0, 0,  1, 1, 64'h3,  0, 0,  1, 0, 64'h9,  16'h0004, 16'h0024};
        tbl[21] = '{1, 2, 3, 0,  0, 0, 0,      0, 0,  0, 0, 64'h9,  16'h0000, 16'h0020};
        tbl[22] = '{0, 0, 0, 0,  1, 1, 64'h4,  0, 0,  0, 0, 64'h9,  16'h0000, 16'h0020};
    end

    initial begin
        idle_in();
        rstn = 0;
        #1;
        step();
        step();
        rstn = 1;

        // Reset state, with a get on entry 0 in the first active cycle.
        chk("rst_fresh",     fresh,     16'h0);
        chk("rst_valid_get", valid_get, 16'h0);
        chk("rst_get_data",  get_data,  64'h0);

        for (int k = 0; k < NV; k++) begin
            idle_in();
            cfg_we = tbl[k].cw; cfg_idx = tbl[k].ci; cfg_type = tbl[k].ct; cfg_peer = tbl[k].cp;
            put = tbl[k].p; put_idx = tbl[k].pi; put_data = tbl[k].pd;
            get = tbl[k].g; get_idx = tbl[k].gi;
            step();
            chk($sformatf("tbl%0d_put", k),   put_success, tbl[k].ep);
            chk($sformatf("tbl%0d_get", k),   get_success, tbl[k].eg);
            chk($sformatf("tbl%0d_data", k),  get_data,    tbl[k].ed);
            chk($sformatf("tbl%0d_fresh", k), fresh,       tbl[k].ef);
            chk($sformatf("tbl%0d_vget", k),  valid_get,   tbl[k].ev);
        end

        // Identity and status.
        idle_in();
        iam_we = 1; iam = 32'h4D; status_we = 1; status = 2'd1; simid_we = 1; simid = 32'd3;
        step();
        chk("id_iam",    iam_q,    32'h4D);
        chk("id_status", status_q, 2'd1);
        chk("id_simid",  simid_q,  32'd3);
        idle_in();
        step();
        chk("id_hold_iam", iam_q, 32'h4D);

        // Reset landing in the middle of a same-cycle put/get on a fresh entry.
        idle_in();
        cfg_we = 1; cfg_idx = 2; cfg_type = 2'd2;
        step();
        idle_in();
        put = 1; put_idx = 1; put_data = 64'h5;
        step();
        chk("mid_fresh_before", fresh, 16'h0004);
        idle_in();
        rstn = 0;
        put = 1; put_idx = 1; put_data = 64'h6; get = 1; get_idx = 2;
        step();
        chk("mid_rst_fresh",  fresh,       16'h0);
        chk("mid_rst_vget",   valid_get,   16'h0);
        chk("mid_rst_get",    get_success, 1'b0);
        chk("mid_rst_put",    put_success, 1'b0);
        chk("mid_rst_data",   get_data,    64'h0);
        chk("mid_rst_iam",    iam_q,       32'h0);
        chk("mid_rst_simid",  simid_q,     32'h0);
        rstn = 1;
        idle_in();
        put = 1; put_idx = 1; put_data = 64'h7; get = 1; get_idx = 2;
        step();
        chk("post_rst_put", put_success, 1'b0);
        chk("post_rst_get", get_success, 1'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            idle_in();
            rstn      = ($urandom_range(0, 699) != 0);
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_idx   = IW'($urandom_range(0, 7));
            cfg_type  = 2'($urandom_range(0, 3));
            cfg_peer  = IW'($urandom_range(0, 7));
            put       = $urandom_range(0, 1) == 1;
            put_idx   = IW'($urandom_range(0, 7));
            put_data  = {$urandom, $urandom};
            get       = $urandom_range(0, 1) == 1;
            get_idx   = IW'($urandom_range(0, 7));
            iam_we    = ($urandom_range(0, 9) == 0);
            iam       = $urandom;
            status_we = ($urandom_range(0, 9) == 0);
            status    = 2'($urandom_range(0, 3));
            simid_we  = ($urandom_range(0, 9) == 0);
            simid     = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
